// File: rtl/imem_responder.sv
// Instruction-memory responder: valid/ready fetch requests, synchronous word array,
// fixed-latency pipeline feeding an in-order response buffer, flush and program-load port.
module imem_responder #(
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned LATENCY   = 1,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   input  logic        flush,
   input  logic        load_we,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
   localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

   logic [31:0]   mem_q [DEPTH];
   logic [AW-1:0] req_idx;
   logic [AW-1:0] load_idx;
   logic          req_err;
   logic          load_ok;
   logic          accept;
   logic          pop;
   logic [31:0]   in_data;

   assign req_idx  = req_addr[AW+1:2];
   assign load_idx = load_addr[AW+1:2];
   assign req_err  = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
   assign load_ok  = (load_addr[1:0] == 2'b00) && (load_addr[31:AW+2] == '0);
   assign accept   = req_valid && req_ready;
   assign pop      = rsp_valid && rsp_ready;
   assign in_data  = req_err ? '0 : mem_q[req_idx];

   // Memory is deliberately not reset; writes are honoured during reset and flush.
   always_ff @(posedge clk) begin
      if (load_we && load_ok) begin
         mem_q[load_idx] <= load_data;
      end
   end

   logic        tail_v;
   logic [31:0] tail_d;
   logic        tail_e;

   // The accept edge itself is the first latency cycle, so only LATENCY-1 stages are registered.
   if (LATENCY == 1) begin : g_direct
      assign tail_v = accept;
      assign tail_d = in_data;
      assign tail_e = req_err;
   end else begin : g_pipe
      localparam int unsigned NS = LATENCY - 1;
      logic        pv_q [NS];
      logic [31:0] pd_q [NS];
      logic        pe_q [NS];

      always_ff @(posedge clk) begin
         pd_q[0] <= in_data;
         pe_q[0] <= req_err;
         for (int unsigned k = 1; k < NS; k++) begin
            pd_q[k] <= pd_q[k-1];
            pe_q[k] <= pe_q[k-1];
         end
         if (reset || flush) begin
            for (int unsigned k = 0; k < NS; k++) begin
               pv_q[k] <= 1'b0;
            end
         end else begin
            pv_q[0] <= accept;
            for (int unsigned k = 1; k < NS; k++) begin
               pv_q[k] <= pv_q[k-1];
            end
         end
      end

      assign tail_v = pv_q[NS-1];
      assign tail_d = pd_q[NS-1];
      assign tail_e = pe_q[NS-1];
   end

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   logic [31:0]   fb_data_q [BUF_DEPTH];
   logic          fb_err_q  [BUF_DEPTH];
   logic [PW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] out_q, out_d;
   logic [31:0]   hold_data_q;
   logic          hold_err_q;

   always_comb begin
      cnt_d = cnt_q + CW'(tail_v) - CW'(pop);
      out_d = out_q + CW'(accept) - CW'(pop);
      if (reset || flush) begin
         cnt_d = '0;
         out_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (tail_v) begin
         fb_data_q[wr_q] <= tail_d;
         fb_err_q[wr_q]  <= tail_e;
      end
      cnt_q <= cnt_d;
      out_q <= out_d;
      if (reset || flush) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (tail_v) wr_q <= ptr_inc(wr_q);
         if (pop)    rd_q <= ptr_inc(rd_q);
      end
      // Tracks whatever is being presented so outputs hold once the buffer drains.
      if (reset) begin
         hold_data_q <= '0;
         hold_err_q  <= 1'b0;
      end else begin
         hold_data_q <= rsp_data;
         hold_err_q  <= rsp_err;
      end
   end

   assign req_ready = !reset && !flush && (out_q < CW'(BUF_DEPTH));
   assign rsp_valid = (cnt_q != '0);
   assign rsp_data  = rsp_valid ? fb_data_q[rd_q] : hold_data_q;
   assign rsp_err   = rsp_valid ? fb_err_q[rd_q]  : hold_err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: one LATENCY=1 instance for streaming, backpressure,
// errors, flush and load port; one LATENCY=3 instance for latency and mid-flight reset.
module tb_imem_responder;

   logic        clk = 1'b0;
   logic        reset, reset3;
   logic        req_valid, req_valid3;
   logic        req_ready, req_ready3;
   logic [31:0] req_addr;
   logic        rsp_valid, rsp_valid3;
   logic        rsp_ready, rsp_ready3;
   logic [31:0] rsp_data, rsp_data3;
   logic        rsp_err, rsp_err3;
   logic        flush;
   logic        load_we;
   logic [31:0] load_addr, load_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   imem_responder #(.DEPTH(256), .LATENCY(1), .BUF_DEPTH(2)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .flush(flush), .load_we(load_we),
      .load_addr(load_addr), .load_data(load_data)
   );

   imem_responder #(.DEPTH(256), .LATENCY(3), .BUF_DEPTH(2)) dut3 (
      .clk(clk), .reset(reset3), .req_valid(req_valid3), .req_ready(req_ready3),
      .req_addr(req_addr), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
      .rsp_data(rsp_data3), .rsp_err(rsp_err3), .flush(flush), .load_we(load_we),
      .load_addr(load_addr), .load_data(load_data)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] prog [4];
      prog[0] = 32'h00000013; prog[1] = 32'h00100093;
      prog[2] = 32'h00200113; prog[3] = 32'h00308193;
      reset = 1'b1; reset3 = 1'b1;
      step(); step();
      for (int i = 0; i < 4; i++) begin
         load_we = 1'b1; load_addr = 32'(i * 4); load_data = prog[i];
         step();
      end
      load_we = 1'b0;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
      checks++; if (req_ready3 !== 1'b0) begin errors++; $display("FAIL reset_req_ready3 got %b exp 0", req_ready3); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
      checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got %h exp 00000000", rsp_data); end
      checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
      reset = 1'b0; reset3 = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_req_ready got %b exp 1", req_ready); end
   endtask

   task automatic test_stream();
      logic [31:0] exp [4];
      exp[0] = 32'h00000013; exp[1] = 32'h00100093;
      exp[2] = 32'h00200113; exp[3] = 32'h00308193;
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1; req_addr = 32'(i * 4);
         #1;
         checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL stream_ready%0d got %b exp 1", i, req_ready); end
         step();
         checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL stream_valid%0d got %b exp 1", i, rsp_valid); end
         checks++; if (rsp_data !== exp[i]) begin errors++; $display("FAIL stream_data%0d got %h exp %h", i, rsp_data, exp[i]); end
         checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL stream_err%0d got %b exp 0", i, rsp_err); end
      end
      req_valid = 1'b0;
      step();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %b exp 0", rsp_valid); end
   endtask

   task automatic test_backpressure();
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_addr = 32'h0;
      step();
      req_addr = 32'h4;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_second_ready got %b exp 1", req_ready); end
      step();
      req_addr = 32'h8;
      #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b exp 0", req_ready); end
      step();
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready2 got %b exp 0", req_ready); end
      checks++; if (rsp_data !== 32'h00000013) begin errors++; $display("FAIL bp_stable_data got %h exp 00000013", rsp_data); end
      rsp_ready = 1'b1;
      step();
      checks++; if (rsp_data !== 32'h00100093) begin errors++; $display("FAIL bp_pop2_data got %h exp 00100093", rsp_data); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_after_pop_ready got %b exp 1", req_ready); end
      step();
      req_valid = 1'b0;
      checks++; if (rsp_data !== 32'h00200113) begin errors++; $display("FAIL bp_addr8_data got %h exp 00200113", rsp_data); end
      step();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_empty_valid got %b exp 0", rsp_valid); end
      checks++; if (rsp_data !== 32'h00200113) begin errors++; $display("FAIL bp_hold_data got %h exp 00200113", rsp_data); end
   endtask

   task automatic test_err();
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_addr = 32'h6;
      step();
      checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL err_misalign got %b exp 1", rsp_err); end
      checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL err_misalign_data got %h exp 00000000", rsp_data); end
      req_addr = 32'h400;
      step();
      checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL err_range got %b exp 1", rsp_err); end
      checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL err_range_data got %h exp 00000000", rsp_data); end
      req_addr = 32'h3FC;
      step();
      checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL err_last_word got %b exp 0", rsp_err); end
      req_addr = 32'h2;
      step();
      req_valid = 1'b0;
      step();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL err_drain got %b exp 0", rsp_valid); end
      checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL err_hold got %b exp 1", rsp_err); end
   endtask

   task automatic test_flush();
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_addr = 32'h0;
      step();
      req_addr = 32'h4;
      step();
      flush = 1'b1; req_addr = 32'h8;
      #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_full_ready got %b exp 0", req_ready); end
      step();
      flush = 1'b0; req_valid = 1'b0;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", rsp_valid); end
      rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_stale%0d got %b exp 0", i, rsp_valid); end
      end
      // one outstanding: flush alone must block the otherwise-open request
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_addr = 32'h0;
      step();
      flush = 1'b1; req_addr = 32'hC;
      #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_gate_ready got %b exp 0", req_ready); end
      step();
      flush = 1'b0; req_valid = 1'b0;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_gate_valid got %b exp 0", rsp_valid); end
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_addr = 32'h8;
      step();
      req_valid = 1'b0;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL flush_next_valid got %b exp 1", rsp_valid); end
      checks++; if (rsp_data !== 32'h00200113) begin errors++; $display("FAIL flush_next_data got %h exp 00200113", rsp_data); end
      step();
   endtask

   task automatic test_latency3();
      rsp_ready3 = 1'b1;
      req_valid3 = 1'b1; req_addr = 32'h4;
      step();
      req_valid3 = 1'b0;
      checks++; if (rsp_valid3 !== 1'b0) begin errors++; $display("FAIL lat3_t1 got %b exp 0", rsp_valid3); end
      step();
      checks++; if (rsp_valid3 !== 1'b0) begin errors++; $display("FAIL lat3_t2 got %b exp 0", rsp_valid3); end
      step();
      checks++; if (rsp_valid3 !== 1'b1) begin errors++; $display("FAIL lat3_t3 got %b exp 1", rsp_valid3); end
      checks++; if (rsp_data3 !== 32'h00100093) begin errors++; $display("FAIL lat3_data got %h exp 00100093", rsp_data3); end
      step();
      checks++; if (rsp_valid3 !== 1'b0) begin errors++; $display("FAIL lat3_drain got %b exp 0", rsp_valid3); end
      req_valid3 = 1'b1;
      step();
      req_valid3 = 1'b0; reset3 = 1'b1;
      #1;
      checks++; if (req_ready3 !== 1'b0) begin errors++; $display("FAIL lat3_reset_ready got %b exp 0", req_ready3); end
      step();
      reset3 = 1'b0;
      checks++; if (rsp_data3 !== 32'h0) begin errors++; $display("FAIL lat3_reset_data got %h exp 00000000", rsp_data3); end
      checks++; if (rsp_err3 !== 1'b0) begin errors++; $display("FAIL lat3_reset_err got %b exp 0", rsp_err3); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (rsp_valid3 !== 1'b0) begin errors++; $display("FAIL lat3_reset_valid%0d got %b exp 0", i, rsp_valid3); end
         step();
      end
   endtask

   task automatic test_load_rbw();
      logic [31:0] laddr [4];
      logic [31:0] ldata [4];
      logic [31:0] exp   [4];
      laddr[0] = 32'h8;   ldata[0] = 32'hDEADBEEF; exp[0] = 32'h00200113;
      laddr[1] = 32'h9;   ldata[1] = 32'h11111111; exp[1] = 32'hDEADBEEF;
      laddr[2] = 32'h408; ldata[2] = 32'h22222222; exp[2] = 32'hDEADBEEF;
      laddr[3] = 32'h0;   ldata[3] = 32'h0;        exp[3] = 32'hDEADBEEF;
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1; req_addr = 32'h8;
         load_we = (i < 3); load_addr = laddr[i]; load_data = ldata[i];
         step();
         checks++; if (rsp_data !== exp[i]) begin errors++; $display("FAIL load_rbw%0d got %h exp %h", i, rsp_data, exp[i]); end
      end
      load_we = 1'b0; req_valid = 1'b0;
      step();
   endtask

   initial begin
      reset = 1'b1; reset3 = 1'b1;
      req_valid = 1'b0; req_valid3 = 1'b0; req_addr = '0;
      rsp_ready = 1'b0; rsp_ready3 = 1'b0; flush = 1'b0;
      load_we = 1'b0; load_addr = '0; load_data = '0;
      test_reset();
      test_stream();
      test_backpressure();
      test_err();
      test_flush();
      test_latency3();
      test_load_rbw();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder serving the fetch stage over a valid/ready request/response protocol.
- Accepts word-fetch requests, reads a synchronous word array, returns data after a fixed pipeline latency through a small response buffer.
- Supports a fetch flush on branch/jump redirect, and a program-load write port used by testbenches and boot logic.

Parameters:
DEPTH, 256, number of 32-bit instruction words; power of two.
LATENCY, 1, cycles from request accept to response entering the buffer; legal range 1..4.
BUF_DEPTH, 2, maximum outstanding requests (in pipeline plus buffered); legal range 1..4.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  fetch request valid.
req_ready  out  1  responder can accept a request.
req_addr  in  32  byte address of the instruction.
rsp_valid  out  1  response available.
rsp_ready  in  1  fetch stage accepts the response.
rsp_data  out  32  instruction word.
rsp_err  out  1  request was misaligned or out of range.
flush  in  1  discard all in-flight and buffered responses.
load_we  in  1  program-load write enable.
load_addr  in  32  byte address for the load write.
load_data  in  32  word written.

Behaviour:
- Reset (sync, active-high): pipeline valids cleared, buffer emptied, outstanding count = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0. Memory contents are not cleared. req_ready = 0 while reset is high.
- req_ready = !reset && !flush && (outstanding < BUF_DEPTH). It is combinational from registered state and flush only; there is no path from rsp_ready.
- Accept: req_valid && req_ready on a rising edge.
  - Word index = req_addr[log2(DEPTH)+1:2].
  - err = (req_addr[1:0] != 0) || (req_addr[31:2] >= DEPTH).
  - Data = mem[index], or 32'h0 when err.
  - The memory read is sampled in the accept cycle.
- Latency: an accepted request enters the buffer exactly LATENCY cycles after accept. With an empty buffer, rsp_valid rises LATENCY cycles after the accept edge.
- Ordering: responses are strictly in request order.
- Response handshake: rsp_valid && rsp_ready pops one entry.
  - rsp_data and rsp_err are stable while rsp_valid && !rsp_ready.
  - rsp_data and rsp_err hold their last value when rsp_valid = 0.
- Outstanding count:
  - +1 on accept, -1 on pop; both in one cycle leaves it unchanged.
  - Never exceeds BUF_DEPTH, so the buffer cannot overflow. This covers sustained rsp_ready = 0.
- Full throughput: with LATENCY = 1, BUF_DEPTH >= 2 and rsp_ready held high, one request is accepted and one response delivered per cycle.
- Flush (priority over everything except reset):
  - In the flush cycle no request is accepted.
  - At the edge, all pipeline stages and buffer entries are invalidated and outstanding = 0.
  - rsp_valid = 0 the following cycle.
  - A response popped in the flush cycle counts as delivered.
- Load port:
  - load_we writes mem[load_addr[log2(DEPTH)+1:2]] = load_data at the edge.
  - Writes with out-of-range or misaligned load_addr are ignored.
  - Same-cycle read of the same word returns the old data (read-before-write).
  - Writes are allowed during reset and flush.
- Reset mid-operation: all in-flight requests are discarded identically to flush; no response is produced for them.

Test Plan:
- Load mem[0..3] = 0x00000013, 0x00100093, 0x00200113, 0x00308193; LATENCY = 1; request addr 0,4,8,12 back-to-back with rsp_ready = 1 -> rsp_valid rises 1 cycle after first accept, data returned in order over 4 consecutive cycles, rsp_err = 0.
- BUF_DEPTH = 2, rsp_ready = 0, req_valid held with addr 0,4,8 -> two accepts, then req_ready = 0. rsp_data = 0x00000013 stable. Raising rsp_ready pops 0x00000013 then 0x00100093, and addr 8 is accepted only after the first pop.
- Request addr 0x6 -> rsp_err = 1, rsp_data = 0. Request addr 0x400 (DEPTH = 256) -> rsp_err = 1, rsp_data = 0.
- Two requests outstanding, flush pulsed one cycle with req_valid = 1 -> req_ready = 0 in the flush cycle, rsp_valid = 0 next cycle, no stale response ever appears. Next request addr 8 returns 0x00200113.
- LATENCY = 3: accept addr 4 at cycle t -> rsp_valid first high at t+3 with 0x00100093. Assert reset at t+1 -> no response, outputs at reset values.
- load_we to word 2 with 0xDEADBEEF in the same cycle as an accepted fetch of addr 8 -> response 0x00200113; a subsequent fetch of addr 8 -> 0xDEADBEEF.
